vga_rectfill: RTL and testbench

VGA_RECTFILL -- requirements
Module: vga_rectfill

---
 rtl/vga_rectfill.sv | 159 +++++++++++++++
 tb/tb_vga_rectfill.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rectfill.sv
// Rectangle fill engine: a bus-programmed FSM that writes a solid RGB444
// rectangle into a 640x480 frame buffer through an arbitrated VRAM port.
module vga_rectfill #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic [XLEN-1:0] addr,
  input  logic [3:0]      we,
  input  logic [XLEN-1:0] qin,
  output logic [XLEN-1:0] qout,
  input  logic            vblank,
  output logic            vram_req,
  input  logic            vram_gnt,
  output logic            vram_we,
  output logic [18:0]     vram_addr,
  output logic [11:0]     vram_din,
  output logic            irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAITVB, S_SETUP, S_FILL, S_DONE
  } state_t;

  localparam logic [10:0] H_RES = 11'd640;
  localparam logic [10:0] V_RES = 11'd480;

  state_t      state;
  logic        vbsync, irqen, done_flag, vblank_d;
  logic [9:0]  x0, y0, w, h;
  logic [11:0] color;
  logic [9:0]  col, row, last_col, last_row;
  logic [18:0] row_base;

  logic wr, wr_ctrl, wr_status, start, busy, empty, last_pixel, done_set;
  logic [10:0] x_room, y_room, wc, hc;
  logic [18:0] base_calc;

  assign wr        = sel && (we != 4'b0000);
  assign wr_ctrl   = wr && (addr[4:2] == 3'd0);
  assign wr_status = wr && (addr[4:2] == 3'd1);
  assign busy      = (state != S_IDLE);
  assign start     = wr_ctrl && qin[0] && !busy;

  // Clipping and row base are evaluated from the live registers but only
  // consumed in SETUP, so later bus writes cannot disturb a running fill.
  assign empty     = ({1'b0, x0} >= H_RES) || ({1'b0, y0} >= V_RES) ||
                     (w == 10'd0) || (h == 10'd0);
  assign x_room    = H_RES - {1'b0, x0};
  assign y_room    = V_RES - {1'b0, y0};
  assign wc        = ({1'b0, w} < x_room) ? {1'b0, w} : x_room;
  assign hc        = ({1'b0, h} < y_room) ? {1'b0, h} : y_room;
  assign base_calc = ({9'd0, y0} << 9) + ({9'd0, y0} << 7) + {9'd0, x0};

  assign vram_we    = vram_req & vram_gnt;
  assign last_pixel = (col == last_col) && (row == last_row);
  assign done_set   = ((state == S_SETUP) && empty) ||
                      ((state == S_FILL) && vram_we && last_pixel);
  assign irq        = done_flag & irqen;

  always_comb begin
    qout = '0;
    if (sel) begin
      case (addr[4:2])
        3'd0: qout[2:0] = {irqen, vbsync, 1'b0};
        3'd1: qout[1:0] = {done_flag, busy};
        3'd2: begin qout[9:0] = x0; qout[25:16] = y0; end
        3'd3: begin qout[9:0] = w;  qout[25:16] = h;  end
        3'd4: qout[11:0] = color;
        default: qout = '0;
      endcase
    end
  end

  // NOTE: every state bit, including datapath registers, is cleared by rst so
  // that an abort mid-fill leaves no stale address or colour on the VRAM port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      vbsync    <= 1'b0;
      irqen     <= 1'b0;
      done_flag <= 1'b0;
      vblank_d  <= 1'b0;
      x0        <= '0;
      y0        <= '0;
      w         <= '0;
      h         <= '0;
      color     <= '0;
      col       <= '0;
      row       <= '0;
      last_col  <= '0;
      last_row  <= '0;
      row_base  <= '0;
      vram_req  <= 1'b0;
      vram_addr <= '0;
      vram_din  <= '0;
    end else begin
      vblank_d  <= vblank;
      // Completion set wins over a simultaneous write-1-clear.
      done_flag <= done_set | (done_flag & ~(wr_status & qin[1]));
      if (wr_ctrl) begin
        vbsync <= qin[1];
        irqen  <= qin[2];
      end
      if (wr && addr[4:2] == 3'd2) begin
        x0 <= qin[9:0];
        y0 <= qin[25:16];
      end
      if (wr && addr[4:2] == 3'd3) begin
        w <= qin[9:0];
        h <= qin[25:16];
      end
      if (wr && addr[4:2] == 3'd4) color <= qin[11:0];

      case (state)
        S_IDLE:
          if (start) state <= qin[1] ? S_WAITVB : S_SETUP;
        S_WAITVB:
          if (vblank && !vblank_d) state <= S_SETUP;
        S_SETUP: begin
          if (empty) begin
            state <= S_DONE;
          end else begin
            last_col  <= 10'(wc - 11'd1);
            last_row  <= 10'(hc - 11'd1);
            col       <= '0;
            row       <= '0;
            row_base  <= base_calc;
            vram_addr <= base_calc;
            vram_din  <= color;
            vram_req  <= 1'b1;
            state     <= S_FILL;
          end
        end
        S_FILL:
          if (vram_we) begin
            if (last_pixel) begin
              vram_req <= 1'b0;
              state    <= S_DONE;
            end else if (col == last_col) begin
              col       <= '0;
              row       <= row + 10'd1;
              row_base  <= row_base + 19'd640;
              vram_addr <= row_base + 19'd640;
            end else begin
              col       <= col + 10'd1;
              vram_addr <= vram_addr + 19'd1;
            end
          end
        S_DONE:
          state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rectfill.sv
// Directed bench for vga_rectfill: fills, clipping, grant stalls, vblank sync,
// empty rectangles with interrupt, set-vs-clear priority and mid-fill reset.
module tb_vga_rectfill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  we = '0;
  logic [31:0] qin = '0;
  logic [31:0] qout;
  logic        vblank = 1'b0;
  logic        vram_req;
  logic        vram_gnt = 1'b1;
  logic        vram_we;
  logic [18:0] vram_addr;
  logic [11:0] vram_din;
  logic        irq;

  int total = 0;
  int bad = 0;

  logic [18:0] wr_addr_q[$];
  logic [11:0] wr_data_q[$];

  vga_rectfill #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .we(we), .qin(qin),
    .qout(qout), .vblank(vblank), .vram_req(vram_req), .vram_gnt(vram_gnt),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din), .irq(irq)
  );

  always #5 clk = ~clk;

  // Capture every pixel write between edges, while inputs are stable.
  always @(negedge clk) begin
    if (vram_we === 1'b1) begin
      wr_addr_q.push_back(vram_addr);
      wr_data_q.push_back(vram_din);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] off, input logic [31:0] data);
    sel = 1'b1; addr = {27'd0, off}; qin = data; we = 4'hF;
    tick();
    sel = 1'b0; we = 4'h0; qin = '0;
  endtask

  task automatic bus_read(input logic [4:0] off, output logic [31:0] data);
    sel = 1'b1; addr = {27'd0, off};
    #1;
    data = qout;
    sel = 1'b0;
    #1;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    logic [31:0] st;
    bit ok = 0;
    for (int i = 0; i < max_cycles; i++) begin
      bus_read(5'h04, st);
      if (st[0] == 1'b0) begin ok = 1; break; end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, need idle", name, max_cycles);
    end
  endtask

  task automatic clear_capture();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int o = 0; o < 5; o++) begin
      bus_read(5'(o * 4), rd);
      total++;
      if (rd !== 32'd0) begin
        bad++; $display("FAIL reset_reg%0d: got %h need 0", o, rd);
      end
    end
    total++;
    if ({vram_req, vram_we, irq} !== 3'b000 || vram_addr !== 19'd0 || vram_din !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs: req=%b we=%b irq=%b addr=%0d din=%h need all 0",
               vram_req, vram_we, irq, vram_addr, vram_din);
    end
  endtask

  // 4x2 block at (10,20) in red; also checks the two-cycle start latency.
  task automatic test_basic_fill(input string name);
    logic [18:0] exp_addr [8] = '{19'd12810, 19'd12811, 19'd12812, 19'd12813,
                                  19'd13450, 19'd13451, 19'd13452, 19'd13453};
    logic [31:0] st;
    clear_capture();
    vram_gnt = 1'b1;
    bus_write(5'h08, (32'd20 << 16) | 32'd10);
    bus_write(5'h0C, (32'd2 << 16) | 32'd4);
    bus_write(5'h10, 32'h0000_0F00);
    bus_write(5'h00, 32'h1);
    total++;
    if (vram_req !== 1'b0) begin
      bad++; $display("FAIL %s_lat1: vram_req=%b need 0", name, vram_req);
    end
    tick();
    total++;
    if (vram_req !== 1'b1) begin
      bad++; $display("FAIL %s_lat2: vram_req=%b need 1", name, vram_req);
    end
    wait_idle(name, 40);
    total++;
    if (wr_addr_q.size() != 8) begin
      bad++; $display("FAIL %s_count: got %0d writes need 8", name, wr_addr_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== 12'hF00) begin
          bad++;
          $display("FAIL %s_px%0d: got addr %0d data %h need addr %0d data f00",
                   name, i, wr_addr_q[i], wr_data_q[i], exp_addr[i]);
        end
      end
    end
    bus_read(5'h04, st);
    total++;
    if (st !== 32'h2) begin
      bad++; $display("FAIL %s_status: got %h need 2", name, st);
    end
    bus_write(5'h04, 32'h2);
  endtask

  task automatic test_clip();
    clear_capture();
    bus_write(5'h08, (32'd479 << 16) | 32'd638);
    bus_write(5'h0C, (32'd5 << 16) | 32'd5);
    bus_write(5'h10, 32'h0000_00A5);
    bus_write(5'h00, 32'h1);
    wait_idle("clip", 40);
    total++;
    if (wr_addr_q.size() != 2) begin
      bad++; $display("FAIL clip_count: got %0d writes need 2", wr_addr_q.size());
    end else begin
      total++;
      if (wr_addr_q[0] !== 19'd307198 || wr_addr_q[1] !== 19'd307199 ||
          wr_data_q[0] !== 12'h0A5 || wr_data_q[1] !== 12'h0A5) begin
        bad++;
        $display("FAIL clip_px: got %0d/%h %0d/%h need 307198/0a5 307199/0a5",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
      end
    end
    bus_write(5'h04, 32'h2);
  endtask

  task automatic test_stall();
    logic [18:0] exp_addr [8] = '{19'd12810, 19'd12811, 19'd12812, 19'd12813,
                                  19'd13450, 19'd13451, 19'd13452, 19'd13453};
    logic [3:0]  pat = 4'b1001;
    logic [31:0] st;
    bit          done = 0;
    clear_capture();
    bus_write(5'h08, (32'd20 << 16) | 32'd10);
    bus_write(5'h0C, (32'd2 << 16) | 32'd4);
    bus_write(5'h10, 32'h0000_0F00);
    bus_write(5'h00, 32'h1);
    for (int i = 0; i < 80 && !done; i++) begin
      vram_gnt = pat[i % 4];
      tick();
      bus_read(5'h04, st);
      done = (st[0] == 1'b0);
    end
    vram_gnt = 1'b1;
    total++;
    if (!done) begin
      bad++; $display("FAIL stall_timeout: still busy, need idle");
    end
    total++;
    if (wr_addr_q.size() != 8) begin
      bad++; $display("FAIL stall_count: got %0d writes need 8", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (wr_addr_q[i] !== exp_addr[i]) begin
          bad++;
          $display("FAIL stall_px%0d: got %0d need %0d", i, wr_addr_q[i], exp_addr[i]);
        end
      end
    end
    bus_write(5'h04, 32'h2);
  endtask

  task automatic test_vbsync();
    bit early = 0;
    bit seen = 0;
    clear_capture();
    vblank = 1'b1;
    tick(); tick();
    bus_write(5'h00, 32'h3);
    for (int i = 0; i < 6; i++) begin tick(); if (vram_req) early = 1; end
    vblank = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (vram_req) early = 1; end
    total++;
    if (early) begin
      bad++; $display("FAIL vbsync_early: vram_req seen before vblank rise, need none");
    end
    vblank = 1'b1;
    for (int i = 0; i < 5 && !seen; i++) begin tick(); seen = vram_req; end
    total++;
    if (!seen) begin
      bad++; $display("FAIL vbsync_go: vram_req=0 after vblank rise, need 1");
    end
    wait_idle("vbsync", 40);
    total++;
    if (wr_addr_q.size() != 8) begin
      bad++; $display("FAIL vbsync_count: got %0d writes need 8", wr_addr_q.size());
    end
    vblank = 1'b0;
    bus_write(5'h00, 32'h0);
    bus_write(5'h04, 32'h2);
  endtask

  task automatic test_empty(input string name, input logic [31:0] pos,
                            input logic [31:0] size);
    logic [31:0] st;
    clear_capture();
    bus_write(5'h08, pos);
    bus_write(5'h0C, size);
    bus_write(5'h00, 32'h5);
    tick();
    bus_read(5'h04, st);
    total++;
    if (st[1] !== 1'b1 || irq !== 1'b1) begin
      bad++; $display("FAIL %s_done: status=%h irq=%b need done=1 irq=1", name, st, irq);
    end
    tick(); tick();
    total++;
    if (wr_addr_q.size() != 0 || irq !== 1'b1) begin
      bad++;
      $display("FAIL %s_nowrite: writes=%0d irq=%b need 0 writes irq=1",
               name, wr_addr_q.size(), irq);
    end
    bus_write(5'h04, 32'h2);
    bus_read(5'h04, st);
    total++;
    if (irq !== 1'b0 || st !== 32'h0) begin
      bad++; $display("FAIL %s_w1c: status=%h irq=%b need 0 0", name, st, irq);
    end
  endtask

  // Clear lands on the same edge that sets DONE; the set must survive.
  task automatic test_set_wins();
    logic [31:0] st;
    bus_write(5'h08, 32'd0);
    bus_write(5'h0C, 32'd0);
    bus_write(5'h00, 32'h1);
    bus_write(5'h04, 32'h2);
    bus_read(5'h04, st);
    total++;
    if (st[1] !== 1'b1) begin
      bad++; $display("FAIL set_wins: done=%b need 1", st[1]);
    end
    tick();
    bus_write(5'h04, 32'h2);
  endtask

  task automatic test_reset_midfill();
    logic [31:0] st, pos;
    bus_write(5'h08, (32'd5 << 16) | 32'd5);
    bus_write(5'h0C, (32'd10 << 16) | 32'd100);
    bus_write(5'h00, 32'h1);
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (vram_req !== 1'b1) begin
      bad++; $display("FAIL midfill_req: vram_req=%b need 1 before reset", vram_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_read(5'h04, st);
    bus_read(5'h08, pos);
    total++;
    if (vram_req !== 1'b0 || vram_we !== 1'b0 || st !== 32'h0 || pos !== 32'h0) begin
      bad++;
      $display("FAIL midfill_rst: req=%b we=%b status=%h pos=%h need 0 0 0 0",
               vram_req, vram_we, st, pos);
    end
    test_basic_fill("after_rst");
  endtask

  initial begin
    test_reset();
    test_basic_fill("basic");
    test_clip();
    test_stall();
    test_vbsync();
    test_empty("w_zero", (32'd20 << 16) | 32'd10, (32'd2 << 16) | 32'd0);
    test_empty("x_700", (32'd20 << 16) | 32'd700, (32'd2 << 16) | 32'd4);
    test_set_wins();
    test_reset_midfill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
